// File: rtl/inst_issue_buffer.sv
// In-order 3-wide issue queue between fetch and decode. It presents the three oldest
// entries every cycle and retires only the slots that decode consumed (the unconsumed youngest slots are rolled back).
module inst_issue_buffer #(
  parameter int DEPTH = 8,
  parameter int XLEN  = 32
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [2:0]                   if_valid,
  input  logic [2:0][31:0]             if_inst,
  input  logic [2:0][XLEN-1:0]         if_pc,
  output logic                         if_ready,
  input  logic [1:0]                   rollback,
  input  logic                         stall,
  input  logic                         squash,
  output logic [2:0]                   id_valid,
  output logic [2:0][31:0]             id_inst,
  output logic [2:0][XLEN-1:0]         id_pc,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [AW-1:0]   head, tail;
  logic [CW-1:0]   occ;
  logic [31:0]     mem_inst [DEPTH];
  logic [XLEN-1:0] mem_pc   [DEPTH];

  logic [1:0]      nvalid, consume, nfetch;
  logic [1:0]      lane_off [3];
  logic [AW-1:0]   slot_idx [3];
  logic            accept;

  // Handshake: if_ready depends only on registered occupancy. A fetch transfers on a
  // rising edge when if_ready=1 and squash=0; otherwise it is dropped and IF must hold it.
  assign if_ready = (occ <= CW'(DEPTH - 3));
  assign accept   = if_ready & ~squash;
  assign count    = occ;

  always_comb begin
    nvalid = (occ >= CW'(3)) ? 2'd3 : occ[1:0];
    consume = 2'd0;
    if (!stall && (nvalid > rollback)) consume = nvalid - rollback;
    nfetch = {1'b0, if_valid[0]} + {1'b0, if_valid[1]} + {1'b0, if_valid[2]};
    // Valid lanes are packed into consecutive entries starting at tail.
    lane_off[0] = 2'd0;
    lane_off[1] = {1'b0, if_valid[0]};
    lane_off[2] = {1'b0, if_valid[0]} + {1'b0, if_valid[1]};
  end

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      slot_idx[i] = head + AW'(i);
      id_valid[i] = (occ > CW'(i));
      id_inst[i]  = id_valid[i] ? mem_inst[slot_idx[i]] : NOP;
      id_pc[i]    = id_valid[i] ? mem_pc[slot_idx[i]] : '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else if (squash) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else begin
      head <= head + AW'(consume);
      tail <= tail + (accept ? AW'(nfetch) : AW'(0));
      occ  <= occ + (accept ? CW'(nfetch) : CW'(0)) - CW'(consume);
    end
  end

  // Storage holds no reset value; entries become visible only through occ.
  always_ff @(posedge clock) begin
    if (accept) begin
      for (int l = 0; l < 3; l++) begin
        if (if_valid[l]) begin
          mem_inst[tail + AW'(lane_off[l])] <= if_inst[l];
          mem_pc[tail + AW'(lane_off[l])]   <= if_pc[l];
        end
      end
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clock) begin
    if (!reset) begin
      assert (occ <= CW'(DEPTH));
      assert (CW'(consume) <= occ);
    end
  end
`endif

endmodule

// File: doc/inst_issue_buffer.md
Name: inst_issue_buffer

Overview:
- 3-wide in-order instruction queue between IF and ID of the 3-way superscalar pipeline.
- Presents up to 3 oldest instructions to ID slots 0..2 every cycle.
- Consumes the hazard unit's `rollback` count (0..3), which gives how many youngest slots were not accepted this cycle; those instructions are re-presented next cycle, shifted toward slot 0.
- Supports full stall and branch squash.

Parameters:
- DEPTH, 8, entries; power of two, >= 4
- XLEN, 32, PC width

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- if_valid  in  3  per-lane fetch valid; lane 0 is the oldest
- if_inst  in  3x32  fetched instruction words
- if_pc  in  3xXLEN  fetched PCs
- if_ready  out  1  buffer can accept a full 3-lane fetch this cycle
- rollback  in  2  count of youngest presented slots not consumed this cycle
- stall  in  1  downstream stall; nothing consumed
- squash  in  1  flush all entries (mispredict)
- id_valid  out  3  slot i holds a valid instruction
- id_inst  out  3x32  slot instruction words
- id_pc  out  3xXLEN  slot PCs
- count  out  $clog2(DEPTH+1)  current occupancy

Behaviour:
- State: circular storage of DEPTH entries {inst, pc}, head pointer, tail pointer, occupancy counter.
- Reset (asynchronous): head=0, tail=0, count=0. Therefore id_valid=000 and if_ready=1. Storage contents are don't-care.
- Outputs are combinational reads of the registered state only.
  - Slot i shows entry (head+i) mod DEPTH.
  - id_valid[i] = (count > i).
  - Invalid slots drive inst=`NOP` and pc=0.
- if_ready = (DEPTH - count >= 3), computed from registered count only. There is no combinational path from rollback, stall or squash to if_ready.
- nvalid = number of set id_valid bits (0..3).
- consume:
  - stall=1: consume = 0.
  - otherwise: consume = max(nvalid - rollback, 0), saturating; e.g. rollback=3 with nvalid=2 gives 0.
- Enqueue:
  - Accepted only when if_ready=1 and squash=0.
  - The set if_valid lanes are compacted in lane order into tail, tail+1, ...
  - nfetch = popcount(if_valid).
  - If if_ready=0 the fetch is dropped; IF must hold it.
- Per rising edge, with no squash:
  - head += consume (mod DEPTH)
  - tail += nfetch·accept (mod DEPTH)
  - count += nfetch·accept − consume
  - Enqueue and dequeue in the same cycle are both legal. An entry enqueued this edge is visible no earlier than the next cycle, giving a minimum IF→ID latency of 1 cycle.
- squash=1 has the highest priority:
  - next state is head=tail=count=0;
  - any same-cycle fetch is discarded;
  - stall and rollback are ignored.
- Pointer wrap: head and tail wrap mod DEPTH; count never exceeds DEPTH or goes below 0.
  - Both bounds are guaranteed by the if_ready rule and the consume clamp.
  - An assertion is provided under simulation.
- Ordering invariant: instructions leave the buffer in exactly the PC order they entered. Rolled-back instructions keep their relative order and move to the lowest slots.
- Reset asserted mid-operation clears state immediately (asynchronously). The first edge after reset deassertion behaves as the empty buffer.

Test Plan:
- Reset → id_valid=000, count=0, if_ready=1. Release reset, drive if_valid=111 with PCs 0x00/0x04/0x08 → next cycle id_valid=111, id_pc={0x00,0x04,0x08}.
- Three valid entries, rollback=2, no fetch → next cycle count=2, id_pc0=0x04, id_pc1=0x08, id_valid=011.
- Three entries, rollback=1, simultaneous fetch 0x0C/0x10/0x14 → next cycle id_pc={0x08,0x0C,0x10}, count=4.
- rollback=3 held while fetching 3 per cycle from empty → count goes 3, 6; then if_ready=0 with count=6; outputs stay at the oldest PC throughout.
- Stream 40 sequential PCs with random rollback (0..3), random stall, and fetch widths 001/011/111 → output PC sequence strictly increasing by 4 with no gaps or duplicates across pointer wrap.
- Five entries plus same-cycle squash and fetch 0x100.. → next cycle count=0, id_valid=000. A following fetch of 0x200 appears in slot 0 one cycle later.
